// File: rtl/kalman_pkg.sv
// rtl/kalman_pkg.sv - shared widths and CAL/RUN state type for the Kalman measurement path
package kalman_pkg;

   localparam int STATE_BITS_DEFAULT = 16;

   typedef enum logic [0:0] {
      ST_CAL = 1'b0,
      ST_RUN = 1'b1
   } dec_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/round_shr_sat.sv
// rtl/round_shr_sat.sv - rounding arithmetic right shift, offset subtract and saturation
module round_shr_sat #(
   parameter int IN_W  = 21,
   parameter int OUT_W = 16,
   parameter int SH_W  = 4
) (
   input  logic signed [IN_W-1:0]  value,
   input  logic        [SH_W-1:0]  shift,
   input  logic signed [OUT_W-1:0] offset,
   output logic signed [OUT_W-1:0] mean,
   output logic signed [OUT_W-1:0] result
);

   logic signed [IN_W-1:0] bias;
   logic signed [IN_W-1:0] biased;
   logic signed [IN_W-1:0] shifted;
   logic signed [OUT_W:0]  diff;

   // Half-away-from-zero: add half an LSB, minus one for negative values so
   // the floor of the arithmetic shift lands on the magnitude-rounded result.
   always_comb begin
      bias = '0;
      if (shift != '0) begin
         bias = IN_W'(1) <<< (shift - SH_W'(1));
         if (value[IN_W-1]) begin
            bias = bias - IN_W'(1);
         end
      end
      biased  = value + bias;
      shifted = biased >>> shift;
      // The mean of OUT_W-bit samples always fits in OUT_W bits.
      mean    = shifted[OUT_W-1:0];
      diff    = {mean[OUT_W-1], mean} - {offset[OUT_W-1], offset};
      if (diff[OUT_W] != diff[OUT_W-1]) begin
         result = diff[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      end else begin
         result = diff[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/measurement_decimator.sv
// rtl/measurement_decimator.sv - offset-calibrated block-average decimator feeding Kalman z_in
import kalman_pkg::*;

module measurement_decimator #(
   parameter int STATE_BITS = STATE_BITS_DEFAULT,
   parameter int DEC_LOG2   = 4,
   parameter int CAL_LOG2   = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic signed [STATE_BITS-1:0] sample_in,
   input  logic                         sample_valid,
   input  logic                         cal_start,
   output logic signed [STATE_BITS-1:0] z_out,
   output logic                         z_valid,
   output logic                         calibrated
);

   localparam int MAX_LOG2 = max_int(CAL_LOG2, DEC_LOG2);
   localparam int ACC_W    = STATE_BITS + MAX_LOG2 + 1;
   localparam int CNT_W    = MAX_LOG2 + 1;
   localparam int SH_W     = $clog2(MAX_LOG2 + 1) + 1;

   dec_state_t                  state;
   logic signed [ACC_W-1:0]     acc;
   logic        [CNT_W-1:0]     cnt;
   logic signed [STATE_BITS-1:0] offset;

   logic signed [ACC_W-1:0]      sum;
   logic        [SH_W-1:0]       shift_n;
   logic        [CNT_W-1:0]      cnt_last;
   logic                         accept;
   logic                         window_done;
   logic signed [STATE_BITS-1:0] mean;
   logic signed [STATE_BITS-1:0] corrected;

   // Window length and running sum including the sample on the current edge
   always_comb begin
      sum         = acc + {{(ACC_W-STATE_BITS){sample_in[STATE_BITS-1]}}, sample_in};
      shift_n     = (state == ST_RUN) ? SH_W'(DEC_LOG2) : SH_W'(CAL_LOG2);
      cnt_last    = (state == ST_RUN) ? CNT_W'((1 << DEC_LOG2) - 1)
                                      : CNT_W'((1 << CAL_LOG2) - 1);
      accept      = sample_valid && !cal_start;
      window_done = accept && (cnt == cnt_last);
   end

   round_shr_sat #(
      .IN_W  (ACC_W),
      .OUT_W (STATE_BITS),
      .SH_W  (SH_W)
   ) u_round_shr_sat (
      .value  (sum),
      .shift  (shift_n),
      .offset (offset),
      .mean   (mean),
      .result (corrected)
   );

   assign calibrated = (state == ST_RUN);

   // All decimator state: accumulate, close windows, load offset or output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_CAL;
         acc     <= '0;
         cnt     <= '0;
         offset  <= '0;
         z_out   <= '0;
         z_valid <= 1'b0;
      end else begin
         z_valid <= 1'b0;
         if (cal_start) begin
            // Offset is kept so the old value stays in force until replaced.
            state <= ST_CAL;
            acc   <= '0;
            cnt   <= '0;
         end else if (window_done) begin
            acc <= '0;
            cnt <= '0;
            if (state == ST_CAL) begin
               offset <= mean;
               state  <= ST_RUN;
            end else begin
               z_out   <= corrected;
               z_valid <= 1'b1;
            end
         end else if (accept) begin
            acc <= sum;
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule
